data_mem_ctrl: RTL

- Responder end of the per-thread LSU data-memory handshake. Serves `NUM_CONSUMERS` LSU channels from one single-port, word-addressed data memory held inside this block.
- Arbitration is round-robin, and the memory access latency is fixed and configurable.
- Sits between the per-thread LSUs of a core and the data memory.
- Provides a backdoor preload port for benches and program load.

---
 rtl/data_mem_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: responder side of the per-thread LSU data-memory handshake.
// Round-robin arbitration over NUM_CONSUMERS channels into one single-port,
// word-addressed memory, with a fixed access latency and a backdoor preload port.
//
// Handshake: a channel raises consumer_mem_valid with addr/data/we and holds it
// until it sees a one-cycle consumer_resp_ready pulse on its bit. Address, data
// and we are captured only at grant. A per-channel served bit, cleared only once
// valid is seen low, stops a request that is still held high for a cycle after
// its response from being served twice.
module data_mem_ctrl #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_mem_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_mem_addr,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_mem_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_mem_we,
    output logic [NUM_CONSUMERS-1:0]           consumer_resp_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_resp_data,
    input  logic                               init_we,
    input  logic [ADDR_BITS-1:0]               init_addr,
    input  logic [DATA_BITS-1:0]               init_data,
    output logic                               ctrl_busy
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_WAIT = 2'd1,
        CTRL_RESP = 2'd2
    } ctrl_state_t;

    ctrl_state_t                      state_q, state_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                 grant_q, grant_d;
    logic [NUM_CONSUMERS-1:0]         served_q, served_d;
    logic [ADDR_BITS-1:0]             addr_q, addr_d;
    logic [DATA_BITS-1:0]             wdata_q, wdata_d;
    logic                             we_q, we_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] resp_data_q, resp_data_d;

    logic [DATA_BITS-1:0]             mem [DEPTH];

    logic [NUM_CONSUMERS-1:0]         eligible;
    logic                             grant_found;
    logic [PTR_W-1:0]                 grant_idx;
    logic [PW1-1:0]                   cand;
    logic                             access_fire;

    // The access happens on the last wait cycle; a reset on that edge abandons it.
    assign access_fire = (state_q == CTRL_WAIT) && (cnt_q == '0) && !reset;

    // Round-robin pick: first eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        eligible    = consumer_mem_valid & ~served_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = {1'b0, rr_ptr_q} + PW1'(k);
            if (cand >= PW1'(NUM_CONSUMERS)) begin
                cand = cand - PW1'(NUM_CONSUMERS);
            end
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state logic for the controller FSM and the captured request.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        case (state_q)
            CTRL_IDLE: begin
                if (grant_found) begin
                    state_d  = CTRL_WAIT;
                    grant_d  = grant_idx;
                    addr_d   = consumer_mem_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
                    wdata_d  = consumer_mem_data[grant_idx*DATA_BITS +: DATA_BITS];
                    we_d     = consumer_mem_we[grant_idx];
                    cnt_d    = CNT_W'(MEM_LATENCY - 1);
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_CONSUMERS - 1)) ? '0
                                                                          : grant_idx + 1'b1;
                end
            end
            CTRL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CTRL_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CTRL_RESP: begin
                state_d = CTRL_IDLE;
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    // Served mask: set when a channel's response cycle ends, cleared while its valid is low.
    always_comb begin
        served_d = served_q;
        if (state_q == CTRL_RESP) begin
            served_d[grant_q] = 1'b1;
        end
        served_d = served_d & consumer_mem_valid;
    end

    // Response data: only the granted slice changes; loads return the pre-write word.
    always_comb begin
        resp_data_d = resp_data_q;
        if (access_fire) begin
            resp_data_d[grant_q*DATA_BITS +: DATA_BITS] = we_q ? wdata_q : mem[addr_q];
        end
    end

    // One-hot response pulse to the granted channel during the response cycle.
    always_comb begin
        consumer_resp_ready = '0;
        if (state_q == CTRL_RESP) begin
            consumer_resp_ready[grant_q] = 1'b1;
        end
    end

    assign consumer_resp_data = resp_data_q;
    assign ctrl_busy          = (state_q != CTRL_IDLE);

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CTRL_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            served_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            served_q    <= served_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Memory array (never reset); a serviced store overrides a same-address backdoor write.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        if (access_fire && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
